maxpool2d_stream: RTL and testbench

2x2 stride-2 max-pooling stage that sits directly downstream of a per-filter featuremap conv2d block. It consumes that block's raster-order IEEE-754 single-precision output stream (valid_out/data_out) and emits one pooled value per 2x2 window, halving both width and height. Its output feeds the next layer's input FIFO write port.

---
 rtl/maxpool2d_stream.sv | 96 +++++++++
 tb/tb_maxpool2d_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_stream.sv
// 2x2 stride-2 max-pooling of a raster-order IEEE-754 single-precision pixel stream.
// Optional output ReLU is enabled by defining MAXPOOL_RELU_EN.
module maxpool2d_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int MW   = DATA_WIDTH - 1;

  // Sign/magnitude ordering; +0 and -0 compare equal so the tie keeps a.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic          sa, sb;
    logic [MW-1:0] ma, mb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ma = a[MW-1:0];
    mb = b[MW-1:0];
    if (ma == '0 && mb == '0) fmax = a;
    else if (sa != sb)        fmax = sa ? b : a;
    else if (!sa)             fmax = (mb > ma) ? b : a;
    else                      fmax = (mb < ma) ? b : a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] out_stage(input logic [DATA_WIDTH-1:0] v);
`ifdef MAXPOOL_RELU_EN
    out_stage = v[DATA_WIDTH-1] ? '0 : v;
`else
    out_stage = v;
`endif
  endfunction

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold_p0;
  logic [DATA_WIDTH-1:0] lb [HALF];
  logic [LW-1:0]         lb_idx;
  logic [DATA_WIDTH-1:0] h_pair;
  logic [DATA_WIDTH-1:0] pool_max;
  logic                  col_last;
  logic                  row_last;

  assign lb_idx   = LW'(col >> 1);
  assign h_pair   = fmax(hold_p0, data_in);
  assign pool_max = fmax(lb[lb_idx], h_pair);
  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));

  // Stage 0: horizontal pairing, raster counters and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold_p0    <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col[0]) hold_p0 <= data_in;
        if (col[0] && row[0]) begin
          valid_out  <= 1'b1;
          data_out   <= out_stage(pool_max);
          frame_done <= col_last && row_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Even rows park their horizontal maxima for the odd row beneath.
  always_ff @(posedge clk) begin
    if (valid_in && col[0] && !row[0]) lb[lb_idx] <= h_pair;
  end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Self-checking bench for maxpool2d_stream: three geometries driven against a window-level model.
module tb_maxpool2d_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  vin;
  logic [2:0]  oo;
  logic [2:0]  vout;
  logic [2:0]  fd;
  logic [2:0]  want;
  logic [31:0] din  [3];
  logic [31:0] dout [3];

  int errors = 0;
  int checks = 0;
  int out_cnt [3];
  int fd_cnt  [3];
  logic [31:0] exp_d [3][$];
  logic        exp_f [3][$];

  maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2)) u_a (
    .clk(clk), .rst(rst[0]), .valid_in(vin[0]), .data_in(din[0]),
    .valid_out(vout[0]), .data_out(dout[0]), .frame_done(fd[0]));
  maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u_b (
    .clk(clk), .rst(rst[1]), .valid_in(vin[1]), .data_in(din[1]),
    .valid_out(vout[1]), .data_out(dout[1]), .frame_done(fd[1]));
  maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) u_c (
    .clk(clk), .rst(rst[2]), .valid_in(vin[2]), .data_in(din[2]),
    .valid_out(vout[2]), .data_out(dout[2]), .frame_done(fd[2]));

  // Floats map onto a signed integer line; +0 and -0 both land on 0.
  function automatic int okey(logic [31:0] v);
    int m;
    m = int'({1'b0, v[30:0]});
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fmax_m(logic [31:0] a, logic [31:0] b);
    return (okey(a) >= okey(b)) ? a : b;
  endfunction

  function automatic logic [31:0] pool_m(logic [31:0] p00, logic [31:0] p01,
                                         logic [31:0] p10, logic [31:0] p11);
    logic [31:0] r;
    r = fmax_m(fmax_m(p00, p01), fmax_m(p10, p11));
`ifdef MAXPOOL_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] rnd_f();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h3F800000;
      3: return 32'hBF800000;
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_px(int k, logic [31:0] d, logic is_oo, int gapmax);
    repeat ($urandom_range(0, gapmax)) begin
      @(negedge clk);
      vin[k] = 1'b0;
    end
    @(negedge clk);
    vin[k] = 1'b1;
    din[k] = d;
    oo[k]  = is_oo;
  endtask

  task automatic idle(int k, int n);
    repeat (n) begin
      @(negedge clk);
      vin[k] = 1'b0;
    end
  endtask

  task automatic run_frame(int k, int w, int h, int gapmax, logic [31:0] pix[$]);
    for (int r = 0; r < h; r += 2)
      for (int c = 0; c < w; c += 2) begin
        exp_d[k].push_back(pool_m(pix[r*w+c], pix[r*w+c+1], pix[(r+1)*w+c], pix[(r+1)*w+c+1]));
        exp_f[k].push_back(r == h-2 && c == w-2);
      end
    for (int i = 0; i < w*h; i++)
      drive_px(k, pix[i], ((i / w) % 2 == 1) && ((i % w) % 2 == 1), gapmax);
  endtask

  task automatic rand_frame(int k, int w, int h, int gapmax);
    logic [31:0] pix[$];
    for (int i = 0; i < w*h; i++) pix.push_back(rnd_f());
    run_frame(k, w, h, gapmax, pix);
  endtask

  always @(posedge clk)
    for (int k = 0; k < 3; k++) want[k] <= !rst[k] && vin[k] && oo[k];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst[k]) begin
        check($sformatf("valid_out[%0d]", k), 32'(vout[k]), 32'(want[k]));
        if (vout[k] === 1'b1) begin
          out_cnt[k]++;
          if (fd[k] === 1'b1) fd_cnt[k]++;
          if (exp_d[k].size() == 0) begin
            check($sformatf("extra_out[%0d]", k), 32'(exp_d[k].size()), 32'd1);
          end else begin
            check($sformatf("data_out[%0d]", k), dout[k], exp_d[k].pop_front());
            check($sformatf("frame_done[%0d]", k), 32'(fd[k]), 32'(exp_f[k].pop_front()));
          end
        end else begin
          check($sformatf("idle_frame_done[%0d]", k), 32'(fd[k]), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] pix[$];
    logic [31:0] part[$];
    int oc, fc;
    rst = 3'b111;
    vin = 3'b000;
    oo  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      din[k] = 32'h0;
      out_cnt[k] = 0;
      fd_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_valid_out", 32'(vout[k]), 32'd0);
      check("reset_data_out", dout[k], 32'h0);
      check("reset_frame_done", 32'(fd[k]), 32'd0);
    end
    rst = 3'b000;

    check("model_basic_w0", pool_m(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000), 32'h40400000);
    check("model_basic_w1", pool_m(32'hBF800000, 32'h3F000000, 32'hC0000000, 32'hBF800000), 32'h3F000000);
`ifdef MAXPOOL_RELU_EN
    check("model_neg", pool_m(32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hBF000000), 32'h00000000);
    check("model_negzero", pool_m(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), 32'h00000000);
`else
    check("model_neg", pool_m(32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hBF000000), 32'hBF000000);
    check("model_negzero", pool_m(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), 32'h80000000);
`endif
    check("model_zero_tie", pool_m(32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000), 32'h00000000);

    // Directed 4x2 frames: basic, negative window, signed-zero windows.
    pix = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000,
            32'h40400000, 32'h3F800000, 32'hC0000000, 32'hBF800000};
    run_frame(0, 4, 2, 0, pix);
    idle(0, 3);
    check("basic_out_count", 32'(out_cnt[0]), 32'd2);
    check("basic_frame_done_count", 32'(fd_cnt[0]), 32'd1);
    pix = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0000000,
            32'h40400000, 32'h3F800000, 32'hC0400000, 32'hBF000000};
    run_frame(0, 4, 2, 0, pix);
    pix = '{32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000,
            32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    run_frame(0, 4, 2, 0, pix);
    for (int f = 0; f < 6; f++) rand_frame(0, 4, 2, 2);
    idle(0, 3);

    // Gapped 4x4 frames.
    for (int f = 0; f < 6; f++) rand_frame(1, 4, 4, 3);
    idle(1, 3);

    // Mid-frame reset on the 4x4 instance after six pixels.
    for (int i = 0; i < 6; i++) part.push_back(rnd_f());
    exp_d[1].push_back(pool_m(part[0], part[1], part[4], part[5]));
    exp_f[1].push_back(1'b0);
    for (int i = 0; i < 6; i++) drive_px(1, part[i], i == 5, 0);
    @(negedge clk);
    vin[1] = 1'b0;
    #2 rst[1] = 1'b1;
    #1;
    check("midreset_valid_out", 32'(vout[1]), 32'd0);
    check("midreset_data_out", dout[1], 32'h0);
    check("midreset_frame_done", 32'(fd[1]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst[1] = 1'b0;
    oc = out_cnt[1];
    rand_frame(1, 4, 4, 1);
    idle(1, 3);
    check("post_reset_out_count", 32'(out_cnt[1] - oc), 32'd4);

    // Two 56x56 frames back to back.
    oc = out_cnt[2];
    fc = fd_cnt[2];
    rand_frame(2, 56, 56, 0);
    rand_frame(2, 56, 56, 0);
    idle(2, 4);
    check("big_out_count", 32'(out_cnt[2] - oc), 32'd1568);
    check("big_frame_done_count", 32'(fd_cnt[2] - fc), 32'd2);

    for (int k = 0; k < 3; k++)
      check($sformatf("drain[%0d]", k), 32'(exp_d[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
